// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared state encoding and counter widths for the trigger qualifier
package trigger_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOW = 3'd0,
    S_IDLE     = 3'd1,
    S_QUAL     = 3'd2,
    S_ACTIVE   = 3'd3,
    S_HOLDOFF  = 3'd4
  } state_t;

  localparam int REJ_BITS = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// clear and inc together load 1, i.e. the clear is applied before the increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] base;

  assign base = clear ? '0 : count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || inc) begin
      count <= (inc && (base != '1)) ? base + WIDTH'(1) : base;
    end
  end

endmodule

// File: rtl/trigger_pulse_qualifier.sv
// rtl/trigger_pulse_qualifier.sv - qualifies trigger high runs into single-cycle events
// Measures accepted run widths and refuses edges during a holdoff window after each event.
module trigger_pulse_qualifier
  import trigger_pkg::*;
#(
  parameter int MIN_WIDTH  = 2,
  parameter int HOLDOFF    = 4,
  parameter int WIDTH_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in,
  output logic                  pulse_out,
  output logic [WIDTH_BITS-1:0] width,
  output logic                  width_valid,
  output logic [REJ_BITS-1:0]   rejected_cnt,
  output logic                  busy
);

  localparam int HB = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HB-1:0] HOLD_LAST = HB'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [WIDTH_BITS:0] MIN_EXT = (WIDTH_BITS + 1)'(MIN_WIDTH);

  state_t              state;
  logic                in_d;
  logic [HB-1:0]       hold_cnt;
  logic [WIDTH_BITS-1:0] cnt;
  logic                cnt_clear;
  logic                cnt_inc;
  logic                rej_inc;
  logic                rise;
  logic                qual_hit;

  assign rise     = in && !in_d;
  assign qual_hit = (({1'b0, cnt} + (WIDTH_BITS + 1)'(1)) == MIN_EXT);
  assign busy     = (state != S_IDLE);

  always_comb begin
    cnt_clear = (state == S_IDLE);
    cnt_inc   = in && ((state == S_IDLE) || (state == S_QUAL) || (state == S_ACTIVE));
    // Short runs and edges landing inside holdoff are both tallied as refusals.
    rej_inc   = ((state == S_QUAL) && !in) || ((state == S_HOLDOFF) && rise);
  end

  sat_counter #(.WIDTH(WIDTH_BITS)) u_run_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .count   (cnt)
  );

  sat_counter #(.WIDTH(REJ_BITS)) u_rej_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (rej_inc),
    .count   (rejected_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_WAIT_LOW;
      in_d        <= 1'b0;
      hold_cnt    <= '0;
      pulse_out   <= 1'b0;
      width       <= '0;
      width_valid <= 1'b0;
    end else begin
      in_d        <= in;
      pulse_out   <= 1'b0;
      width_valid <= 1'b0;
      case (state)
        S_WAIT_LOW: begin
          if (!in) state <= S_IDLE;
        end
        S_IDLE: begin
          if (in) begin
            if (MIN_WIDTH == 1) begin
              pulse_out <= 1'b1;
              state     <= S_ACTIVE;
            end else begin
              state <= S_QUAL;
            end
          end
        end
        S_QUAL: begin
          if (!in) begin
            state <= S_IDLE;
          end else if (qual_hit) begin
            pulse_out <= 1'b1;
            state     <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (!in) begin
            width       <= cnt;
            width_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= (HOLDOFF > 0) ? S_HOLDOFF : S_IDLE;
          end
        end
        S_HOLDOFF: begin
          // A line still high here already had its edge counted; wait for it to drop.
          if (hold_cnt == HOLD_LAST) begin
            state <= in ? S_WAIT_LOW : S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HB'(1);
          end
        end
        default: state <= S_WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_pulse_qualifier.sv
// tb/tb_trigger_pulse_qualifier.sv - directed self-checking bench for trigger_pulse_qualifier
module tb_trigger_pulse_qualifier;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in = 1'b0;

  logic        pulse_a, wv_a, busy_a;
  logic [15:0] width_a, rej_a;
  logic        pulse_b, wv_b, busy_b;
  logic [3:0]  width_b;
  logic [15:0] rej_b;
  logic        pulse_c, wv_c, busy_c;
  logic [15:0] width_c, rej_c;

  int tests = 0;
  int fails = 0;
  int pc_a  = 0;
  int wc_a  = 0;

  always #5 clk = ~clk;

  trigger_pulse_qualifier #(.MIN_WIDTH(2), .HOLDOFF(4), .WIDTH_BITS(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .in(in), .pulse_out(pulse_a), .width(width_a),
    .width_valid(wv_a), .rejected_cnt(rej_a), .busy(busy_a)
  );

  trigger_pulse_qualifier #(.MIN_WIDTH(2), .HOLDOFF(4), .WIDTH_BITS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .in(in), .pulse_out(pulse_b), .width(width_b),
    .width_valid(wv_b), .rejected_cnt(rej_b), .busy(busy_b)
  );

  trigger_pulse_qualifier #(.MIN_WIDTH(1), .HOLDOFF(0), .WIDTH_BITS(16)) dut_c (
    .clk(clk), .reset_n(reset_n), .in(in), .pulse_out(pulse_c), .width(width_c),
    .width_valid(wv_c), .rejected_cnt(rej_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v);
    in = v;
    @(posedge clk);
    #1;
    if (pulse_a) pc_a++;
    if (wv_a) wc_a++;
  endtask

  task automatic do_reset(input logic v);
    reset_n = 1'b0;
    step(v);
    step(v);
    reset_n = 1'b1;
    pc_a = 0;
    wc_a = 0;
  endtask

  initial begin
    // Reset state
    do_reset(1'b0);
    check("rst_pulse", pulse_a, 0);
    check("rst_width", width_a, 0);
    check("rst_wv", wv_a, 0);
    check("rst_rej", rej_a, 0);
    check("rst_busy", busy_a, 1);
    step(0);
    check("idle_busy", busy_a, 0);

    // Clean event: highs T0..T4, low from T5
    step(1);
    check("clean_t0_pulse", pulse_a, 0);
    check("clean_t0_busy", busy_a, 1);
    check("c_t0_pulse", pulse_c, 1);
    step(1);
    check("clean_t1_pulse", pulse_a, 1);
    check("clean_t1_wv", wv_a, 0);
    step(1);
    check("clean_t2_pulse", pulse_a, 0);
    step(1);
    step(1);
    step(0);
    check("clean_t5_wv", wv_a, 1);
    check("clean_t5_width", width_a, 5);
    check("clean_t5_pulse", pulse_a, 0);
    check("c_t5_wv", wv_c, 1);
    check("c_t5_width", width_c, 5);
    check("c_t5_busy", busy_c, 0);
    step(0);
    check("clean_t6_wv", wv_a, 0);
    step(0);
    step(0);
    check("clean_t8_busy", busy_a, 1);
    step(0);
    check("clean_t9_busy", busy_a, 0);
    check("clean_rej", rej_a, 0);
    check("clean_pulses", pc_a, 1);
    check("clean_wvs", wc_a, 1);

    // Glitch
    pc_a = 0; wc_a = 0;
    step(1);
    check("glitch_busy1", busy_a, 1);
    step(0);
    check("glitch_busy2", busy_a, 0);
    check("glitch_rej", rej_a, 1);
    check("glitch_pulses", pc_a, 0);
    check("glitch_wvs", wc_a, 0);
    check("glitch_width_hold", width_a, 5);

    // Holdoff retrigger
    do_reset(1'b0);
    step(0);
    step(1); step(1); step(1);
    step(0);
    check("ret_width", width_a, 3);
    step(1);
    step(1);
    check("ret_rej_edge", rej_a, 1);
    step(0);
    check("ret_h3_busy", busy_a, 1);
    step(0);
    check("ret_h4_busy", busy_a, 0);
    check("ret_rej", rej_a, 1);
    check("ret_pulses", pc_a, 1);

    // Holdoff exit while high
    do_reset(1'b0);
    step(0);
    step(1); step(1); step(1);
    step(0);
    step(1); step(1); step(1); step(1);
    check("hx_busy_waitlow", busy_a, 1);
    check("hx_rej", rej_a, 1);
    step(1); step(1);
    check("hx_no_pulse", pc_a, 1);
    check("hx_rej_still", rej_a, 1);
    step(0);
    check("hx_idle", busy_a, 0);
    step(1);
    step(1);
    check("hx_new_pulse", pulse_a, 1);
    step(0);
    check("hx_new_width", width_a, 2);
    check("hx_pulses", pc_a, 2);

    // In held high through reset release
    do_reset(1'b1);
    step(1); step(1); step(1);
    check("rh_busy", busy_a, 1);
    check("rh_pulses", pc_a, 0);
    check("rh_rej", rej_a, 0);
    step(0);
    check("rh_idle", busy_a, 0);
    step(1);
    step(1);
    check("rh_pulse", pulse_a, 1);

    // Saturation: 20-sample run
    do_reset(1'b0);
    step(0);
    for (int i = 0; i < 20; i++) step(1);
    step(0);
    check("sat_wv_b", wv_b, 1);
    check("sat_width_b", width_b, 15);
    check("sat_width_a", width_a, 20);

    // Reset mid-S_ACTIVE
    do_reset(1'b0);
    step(0);
    step(1); step(1); step(1);
    check("mid_busy", busy_a, 1);
    reset_n = 1'b0;
    step(1);
    check("mid_pulse", pulse_a, 0);
    check("mid_width", width_a, 0);
    check("mid_wv", wv_a, 0);
    check("mid_rej", rej_a, 0);
    check("mid_busy_rst", busy_a, 1);
    reset_n = 1'b1;
    wc_a = 0;
    step(0);
    check("mid_after_wv", wc_a, 0);
    check("mid_after_idle", busy_a, 0);
    check("mid_after_rej", rej_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
